// File: rtl/ex_result_stage_pkg.sv
// Shared definitions for the execute result stage: branch condition
// encodings, the ALU function codes the comparisons rely on, and the
// target alignment rule.
package ex_result_stage_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_funct3_e;

  // The ALU runs SUB for EQ/NE, SLT for LT/GE and SLTU for LTU/GEU, so the
  // stage only ever sees eq_zero and the result lsb.
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_fn_e;

  // With compressed instructions only bit 0 must be clear; otherwise a
  // target has to be 4-byte aligned.
  function automatic logic is_misaligned(input logic [1:0] low_bits,
                                         input logic       support_c);
    return support_c ? low_bits[0] : (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/ex_result_stage_branch_resolve.sv
// Decides whether a control transfer is taken, from the branch condition
// and the two flags the ALU produced for it. Jumps are always taken;
// reserved branch encodings never are.
module ex_result_stage_branch_resolve
  import ex_result_stage_pkg::*;
(
  input  logic       is_branch,
  input  logic [2:0] funct3,
  input  logic       is_jal,
  input  logic       is_jalr,
  input  logic       alu_lsb,
  input  logic       alu_eq_zero,
  output logic       taken
);

  logic cond_met;

  // Map the branch condition onto the ALU flag that answers it.
  always_comb begin
    cond_met = 1'b0;
    case (funct3)
      BR_BEQ:  cond_met = alu_eq_zero;
      BR_BNE:  cond_met = !alu_eq_zero;
      BR_BLT:  cond_met = alu_lsb;
      BR_BGE:  cond_met = !alu_lsb;
      BR_BLTU: cond_met = alu_lsb;
      BR_BGEU: cond_met = !alu_lsb;
      default: cond_met = 1'b0;
    endcase
  end

  assign taken = is_jal | is_jalr | (is_branch & cond_met);

endmodule

// File: rtl/ex_result_stage.sv
// Execute-to-memory pipeline register placed after the ALU. Selects the
// writeback value, resolves branches and jumps, flags misaligned targets,
// raises a one-cycle fetch redirect and hands the bundle on over a
// valid/ready handshake.
module ex_result_stage
  import ex_result_stage_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int SUPPORT_C = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_lsb,
  input  logic            alu_eq_zero,
  input  logic            is_word,
  input  logic            is_branch,
  input  logic [2:0]      funct3,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] br_target,
  input  logic [4:0]      rd_addr,
  input  logic            rd_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd_addr,
  output logic            out_rd_we,
  output logic            out_misaligned,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] LINK_OFFSET = XLEN'(4);

  logic            taken;
  logic            accept;
  logic            target_misaligned;
  logic            redirect_pending;
  logic            next_rd_we;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_result;

  ex_result_stage_branch_resolve u_branch_resolve (
    .is_branch   (is_branch),
    .funct3      (funct3),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .alu_lsb     (alu_lsb),
    .alu_eq_zero (alu_eq_zero),
    .taken       (taken)
  );

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready & !flush;

  // JALR computes its target in the ALU; its low bit is always dropped.
  assign target = is_jalr ? {alu_result[XLEN-1:1], 1'b0} : br_target;

  assign target_misaligned = taken & is_misaligned(target[1:0], SUPPORT_C != 0);

  // Jumps write the link address, word ops write the sign-extended low half.
  always_comb begin
    next_result = alu_result;
    if (is_jal | is_jalr) begin
      next_result = pc + LINK_OFFSET;
    end else if (is_word) begin
      next_result = {{(XLEN-32){alu_result[31]}}, alu_result[31:0]};
    end
  end

  assign next_rd_we = rd_we & !is_branch & (rd_addr != 5'd0) & !target_misaligned;

  assign redirect_valid = out_valid & redirect_pending;

  // Output register; the redirect flag lives only for the cycle after accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid        <= 1'b0;
      out_result       <= '0;
      out_rd_addr      <= '0;
      out_rd_we        <= 1'b0;
      out_misaligned   <= 1'b0;
      redirect_pc      <= '0;
      redirect_pending <= 1'b0;
    end else if (flush) begin
      out_valid        <= 1'b0;
      out_misaligned   <= 1'b0;
      redirect_pending <= 1'b0;
    end else if (accept) begin
      out_valid        <= 1'b1;
      out_result       <= next_result;
      out_rd_addr      <= rd_addr;
      out_rd_we        <= next_rd_we;
      out_misaligned   <= target_misaligned;
      redirect_pc      <= target;
      redirect_pending <= taken & !target_misaligned;
    end else begin
      redirect_pending <= 1'b0;
      if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_result_stage.sv
// Bench for ex_result_stage: directed scenarios followed by a randomized
// instruction stream checked against an operand-level reference model.
module tb_ex_result_stage;

  localparam int XLEN      = 64;
  localparam int SUPPORT_C = 0;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] alu_result;
  logic            alu_lsb;
  logic            alu_eq_zero;
  logic            is_word;
  logic            is_branch;
  logic [2:0]      funct3;
  logic            is_jal;
  logic            is_jalr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] br_target;
  logic [4:0]      rd_addr;
  logic            rd_we;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd_addr;
  logic            out_rd_we;
  logic            out_misaligned;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  ex_result_stage #(.XLEN(XLEN), .SUPPORT_C(SUPPORT_C)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_result     (alu_result),
    .alu_lsb        (alu_lsb),
    .alu_eq_zero    (alu_eq_zero),
    .is_word        (is_word),
    .is_branch      (is_branch),
    .funct3         (funct3),
    .is_jal         (is_jal),
    .is_jalr        (is_jalr),
    .pc             (pc),
    .br_target      (br_target),
    .rd_addr        (rd_addr),
    .rd_we          (rd_we),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_rd_addr    (out_rd_addr),
    .out_rd_we      (out_rd_we),
    .out_misaligned (out_misaligned),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush       = 1'b0;
    in_valid    = 1'b0;
    alu_result  = '0;
    alu_lsb     = 1'b0;
    alu_eq_zero = 1'b0;
    is_word     = 1'b0;
    is_branch   = 1'b0;
    funct3      = 3'b000;
    is_jal      = 1'b0;
    is_jalr     = 1'b0;
    pc          = '0;
    br_target   = '0;
    rd_addr     = '0;
    rd_we       = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0 || out_rd_we !== 1'b0 ||
        out_misaligned !== 1'b0 || out_rd_addr !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_flags: valid=%b redir=%b we=%b mis=%b rd=%0d expected all 0",
               out_valid, redirect_valid, out_rd_we, out_misaligned, out_rd_addr);
    end
    checks++;
    if (out_result !== 64'd0 || redirect_pc !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: result=%h rpc=%h expected 0", out_result, redirect_pc);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_beq_redirect();
    idle_inputs();
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    is_branch   = 1'b1;
    funct3      = 3'b000;
    alu_eq_zero = 1'b1;
    br_target   = 64'h1000;
    rd_addr     = 5'd5;
    rd_we       = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || redirect_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL beq_redirect: valid=%b redir=%b expected 1 1", out_valid, redirect_valid);
    end
    checks++;
    if (redirect_pc !== 64'h1000) begin
      errors++;
      $display("[TB] FAIL beq_target: got %h expected %h", redirect_pc, 64'h1000);
    end
    checks++;
    if (out_rd_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL beq_rd_we: got %b expected 0", out_rd_we);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL beq_drain: valid=%b redir=%b expected 0 0", out_valid, redirect_valid);
    end
  endtask

  task automatic test_word_sext();
    idle_inputs();
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    is_word    = 1'b1;
    alu_result = 64'h0000_0000_8000_0000;
    rd_addr    = 5'd3;
    rd_we      = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (out_result !== 64'hFFFF_FFFF_8000_0000) begin
      errors++;
      $display("[TB] FAIL addw_sext: got %h expected %h", out_result, 64'hFFFF_FFFF_8000_0000);
    end
    checks++;
    if (out_rd_we !== 1'b1 || out_rd_addr !== 5'd3 || redirect_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL addw_ctrl: we=%b rd=%0d redir=%b expected 1 3 0",
               out_rd_we, out_rd_addr, redirect_valid);
    end
    tick();
  endtask

  task automatic test_jalr_align();
    logic exp_mis;
    exp_mis = (SUPPORT_C == 0);
    idle_inputs();
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    is_jalr    = 1'b1;
    alu_result = 64'h2003;
    pc         = 64'h400;
    rd_addr    = 5'd1;
    rd_we      = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (redirect_pc !== 64'h2002) begin
      errors++;
      $display("[TB] FAIL jalr_target: got %h expected %h", redirect_pc, 64'h2002);
    end
    checks++;
    if (out_misaligned !== exp_mis || redirect_valid !== !exp_mis || out_rd_we !== !exp_mis) begin
      errors++;
      $display("[TB] FAIL jalr_misaligned: mis=%b redir=%b we=%b expected %b %b %b",
               out_misaligned, redirect_valid, out_rd_we, exp_mis, !exp_mis, !exp_mis);
    end
    checks++;
    if (out_result !== 64'h404) begin
      errors++;
      $display("[TB] FAIL jalr_link: got %h expected %h", out_result, 64'h404);
    end
    tick();
  endtask

  task automatic test_stall();
    idle_inputs();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    is_branch = 1'b1;
    funct3    = 3'b100;
    alu_lsb   = 1'b1;
    br_target = 64'h2000;
    tick();
    idle_inputs();
    in_valid   = 1'b1;
    alu_result = 64'h55;
    rd_addr    = 5'd7;
    rd_we      = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || redirect_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_first: valid=%b redir=%b in_ready=%b expected 1 1 0",
               out_valid, redirect_valid, in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || redirect_valid !== 1'b0 || in_ready !== 1'b0 ||
          redirect_pc !== 64'h2000 || out_rd_we !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: valid=%b redir=%b in_ready=%b rpc=%h we=%b",
                 k, out_valid, redirect_valid, in_ready, redirect_pc, out_rd_we);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release_ready: got %b expected 1", in_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 64'h55 || redirect_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_next_entry: valid=%b result=%h redir=%b expected 1 55 0",
               out_valid, out_result, redirect_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    is_jal    = 1'b1;
    br_target = 64'h3000;
    flush     = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_accept: valid=%b redir=%b expected 0 0", out_valid, redirect_valid);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    is_jal    = 1'b1;
    br_target = 64'h1001;
    rd_addr   = 5'd2;
    rd_we     = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_misaligned !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_held_mis: valid=%b mis=%b redir=%b expected 1 1 0",
               out_valid, out_misaligned, redirect_valid);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_misaligned !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_stall: valid=%b mis=%b redir=%b expected 0 0 0",
               out_valid, out_misaligned, redirect_valid);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    alu_result = 64'hDEAD_BEEF;
    rd_addr    = 5'd9;
    rd_we      = 1'b1;
    tick();
    idle_inputs();
    tick();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || out_rd_we !== 1'b0 ||
        out_rd_addr !== 5'd0 || redirect_valid !== 1'b0 || redirect_pc !== 64'd0 ||
        out_misaligned !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: valid=%b result=%h we=%b rd=%0d expected all 0",
               out_valid, out_result, out_rd_we, out_rd_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_release: in_ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_random_stream();
    logic            m_valid = 1'b0;
    logic            m_pend  = 1'b0;
    logic [XLEN-1:0] m_result = '0;
    logic [XLEN-1:0] m_rpc    = '0;
    logic [4:0]      m_rd     = '0;
    logic            m_we     = 1'b0;
    logic            m_mis    = 1'b0;
    logic [XLEN-1:0] a, b, alu, tgt, res;
    logic            tk, mis, wd, ew, acc;
    int              op;
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++;
      if (out_valid !== m_valid || redirect_valid !== (m_valid && m_pend)) begin
        errors++;
        $display("[TB] FAIL rand_valid cyc%0d: valid=%b redir=%b expected %b %b",
                 cyc, out_valid, redirect_valid, m_valid, m_valid && m_pend);
      end
      if (m_valid) begin
        checks++;
        if (out_result !== m_result || out_rd_addr !== m_rd || out_rd_we !== m_we ||
            out_misaligned !== m_mis || redirect_pc !== m_rpc) begin
          errors++;
          $display("[TB] FAIL rand_data cyc%0d: res=%h rd=%0d we=%b mis=%b rpc=%h expected %h %0d %b %b %h",
                   cyc, out_result, out_rd_addr, out_rd_we, out_misaligned, redirect_pc,
                   m_result, m_rd, m_we, m_mis, m_rpc);
        end
      end
      idle_inputs();
      op = $urandom_range(0, 9);
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = a ^ 64'h8000_0000_0000_0000;
      alu = {$urandom, $urandom};
      tk  = 1'b0;
      wd  = 1'b0;
      case (op)
        0: begin funct3 = 3'b000; alu = a - b; tk = (a == b); end
        1: begin funct3 = 3'b001; alu = a - b; tk = (a != b); end
        2: begin funct3 = 3'b100; tk = ($signed(a) < $signed(b)); alu = {63'd0, tk}; end
        3: begin funct3 = 3'b101; tk = !($signed(a) < $signed(b)); alu = {63'd0, !tk}; end
        4: begin funct3 = 3'b110; tk = (a < b); alu = {63'd0, tk}; end
        5: begin funct3 = 3'b111; tk = !(a < b); alu = {63'd0, !tk}; end
        6: begin funct3 = 3'($urandom_range(2, 3)); tk = 1'b0; end
        7: begin is_jal = 1'b1; tk = 1'b1; end
        8: begin is_jalr = 1'b1; tk = 1'b1; alu = a + {{52{b[11]}}, b[11:0]}; end
        default: begin wd = 1'($urandom); alu = a + b; end
      endcase
      is_branch   = (op <= 6);
      is_word     = wd;
      alu_result  = alu;
      alu_lsb     = alu[0];
      alu_eq_zero = (alu == 64'd0);
      pc          = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                                : ({$urandom, $urandom} & ~64'h3);
      br_target   = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 2) == 0) br_target = br_target | 64'($urandom_range(1, 3));
      rd_addr     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      rd_we       = ($urandom_range(0, 4) != 0);
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 19) == 0);
      tgt = (op == 8) ? (alu & ~64'd1) : br_target;
      mis = tk && ((SUPPORT_C != 0) ? (tgt[0] == 1'b1) : ((tgt % 4) != 0));
      res = (op == 7 || op == 8) ? pc + 64'd4
          : wd ? {{32{alu[31]}}, alu[31:0]} : alu;
      ew  = rd_we && (op > 6) && (rd_addr != 5'd0) && !mis;
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++;
        $display("[TB] FAIL rand_in_ready cyc%0d: got %b expected %b", cyc, in_ready, !m_valid || out_ready);
      end
      @(posedge clk);
      acc = in_valid && (!m_valid || out_ready) && !flush;
      if (flush) begin
        m_valid = 1'b0;
        m_pend  = 1'b0;
        m_mis   = 1'b0;
      end else if (acc) begin
        m_valid  = 1'b1;
        m_result = res;
        m_rd     = rd_addr;
        m_we     = ew;
        m_mis    = mis;
        m_rpc    = tgt;
        m_pend   = tk && !mis;
      end else begin
        m_pend = 1'b0;
        if (out_ready) m_valid = 1'b0;
      end
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    $display("[TB] starting ex_result_stage bench");
    test_reset();
    test_beq_redirect();
    test_word_sext();
    test_jalr_align();
    test_stall();
    test_flush();
    test_async_reset();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
